// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register feeding a 2-entry {pc, instr} FIFO toward decode
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst          - asynchronous active-high reset
//   imem_addr    - byte address to instruction memory (straight from the PC register)
//   imem_rd      - instruction word returned combinationally for imem_addr
//   fetch_en     - allows new fetches into the FIFO
//   redirect     - flush buffered entries and restart fetch at redirect_pc
//   redirect_pc  - redirect target byte address (low two bits ignored)
//   out_valid    - head instruction available
//   out_ready    - decode accepts the head instruction
//   out_instr    - head instruction word
//   out_pc       - byte address of out_instr
//   fetch_count  - delivered-instruction counter; tied to 0 unless FETCH_COUNT_EN is defined
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    input  logic        fetch_en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic [31:0] fetch_count
);
    logic [31:0] pc;
    logic [1:0]  count;
    logic        rd_ptr;
    logic        wr_ptr;
    logic [31:0] fifo_pc    [2];
    logic [31:0] fifo_instr [2];
    logic        pop;
    logic        push;

    assign imem_addr = pc;
    assign out_valid = count != 2'd0;
    assign out_instr = fifo_instr[rd_ptr];
    assign out_pc    = fifo_pc[rd_ptr];
    assign pop       = out_valid && out_ready;
    // a full FIFO can still accept when the head leaves in the same cycle
    assign push      = fetch_en && !redirect && (count < 2'd2 || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc            <= RESET_PC;
            count         <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            fifo_pc[0]    <= '0;
            fifo_pc[1]    <= '0;
            fifo_instr[0] <= '0;
            fifo_instr[1] <= '0;
        end else if (redirect) begin
            // masking keeps every redirect_pc bit in use while word-aligning the target
            pc     <= redirect_pc & 32'hFFFF_FFFC;
            count  <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
        end else begin
            if (push) begin
                fifo_pc[wr_ptr]    <= pc;
                fifo_instr[wr_ptr] <= imem_rd;
                wr_ptr             <= ~wr_ptr;
                pc                 <= pc + 32'd4;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

`ifdef FETCH_COUNT_EN
    // a pop coinciding with redirect is still a delivery, so count pops unconditionally
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fetch_count <= '0;
        else if (pop)
            fetch_count <= fetch_count + 32'd1;
    end
`else
    assign fetch_count = '0;
`endif
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000: the byte address of the first fetch after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port imem_addr, output, 32 bits: byte address to the instruction memory, which indexes words by imem_addr[31:2].
REQ-005 The block SHALL have port imem_rd, input, 32 bits: instruction word, combinationally valid in the same cycle as imem_addr.
REQ-006 The block SHALL have port fetch_en, input, 1 bit: permits new fetches when high.
REQ-007 The block SHALL have port redirect, input, 1 bit: branch/jump redirect request.
REQ-008 The block SHALL have port redirect_pc, input, 32 bits: redirect target byte address.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the head instruction is available to decode.
REQ-010 The block SHALL have port out_ready, input, 1 bit: decode accepts the head instruction.
REQ-011 The block SHALL have port out_instr, output, 32 bits: head instruction word.
REQ-012 The block SHALL have port out_pc, output, 32 bits: byte address of out_instr.
REQ-013 The block SHALL have port fetch_count, output, 32 bits: count of delivered instructions (see REQ-030).

Function
REQ-014 The block SHALL hold a 32-bit PC register, and imem_addr SHALL equal PC directly, with no combinational path from any input to imem_addr.
REQ-015 The block SHALL contain a 2-entry FIFO of {pc, instr} pairs, and out_valid, out_instr and out_pc SHALL be driven from the head entry.
REQ-016 pop SHALL be defined as out_valid && out_ready.
REQ-017 push SHALL be defined as fetch_en && !redirect && (count < 2 || pop).
REQ-018 On push, the block SHALL write {PC, imem_rd} at the FIFO tail and set PC <= PC + 4, wrapping modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-019 When push and pop occur in the same cycle, count SHALL be unchanged, including at count 2, and program order SHALL be preserved.
REQ-020 A push issued in cycle N SHALL be visible on the outputs in cycle N+1, giving a fetch-to-output latency of 1 cycle.
REQ-021 While out_valid && !out_ready, out_instr and out_pc SHALL remain stable unless redirect is asserted.
REQ-022 When fetch_en is low, there SHALL be no push and PC SHALL hold; existing entries continue to drain via pop.
REQ-023 redirect SHALL have highest priority: on the next edge, count <= 0 and PC <= {redirect_pc[31:2], 2'b00}, and no push occurs in the redirect cycle.
REQ-024 A pop completing in the same cycle as redirect SHALL count as delivered; all other entries SHALL be discarded.
REQ-025 For a redirect asserted in cycle N, out_valid SHALL be 0 in cycle N+1, and the target instruction SHALL appear in cycle N+2 if fetch_en is high.
REQ-026 Back-to-back redirects SHALL each take effect, with the last one winning.

Reset
REQ-027 While rst is high, regardless of clk, the block SHALL drive PC = RESET_PC, count = 0, FIFO pointers = 0, and all storage = 0.
REQ-028 During reset, the outputs SHALL be out_valid = 0, out_instr = 0, out_pc = 0, imem_addr = RESET_PC and fetch_count = 0.
REQ-029 Reset asserted mid-operation SHALL abandon all buffered entries; the first fetch after deassertion SHALL be from RESET_PC.

Configuration
REQ-030 With macro FETCH_COUNT_EN defined, fetch_count SHALL be a register that increments by 1 on each pop and wraps at 2^32.
REQ-031 Without FETCH_COUNT_EN, fetch_count SHALL be constant 0, no counter register SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-032 Reset release with fetch_en=1, out_ready=1, and memory words 0x00100093, 0x00200113 at word addresses 0 and 1 -> first cycle: imem_addr=0, out_valid=0; next cycle: out_instr=0x00100093, out_pc=0; following cycle: out_instr=0x00200113, out_pc=4.
REQ-033 out_ready=0 for 5 cycles, fetch_en=1 -> FIFO fills to 2 entries at pc 0 and 4, imem_addr holds at 8, and out_instr/out_pc remain stable; on out_ready=1, entries are delivered in order 0, 4, 8.
REQ-034 redirect=1 with redirect_pc=0x0000_0043 while 2 entries are buffered -> next cycle out_valid=0 and imem_addr=0x40; the cycle after, out_pc=0x40.
REQ-035 PC=0xFFFF_FFFC, push -> the next imem_addr is 0x0000_0000, and the FIFO holds pc 0xFFFF_FFFC followed by pc 0.
REQ-036 rst pulsed mid-stream with 2 entries buffered -> out_valid=0 immediately (asynchronous), imem_addr=RESET_PC, fetch_count=0.
REQ-037 With FETCH_COUNT_EN defined, 10 pops -> fetch_count=10; without the macro, fetch_count=0 throughout.
